// File: rtl/riscv_defines.sv
// Shared encodings for the load path: memory access kind, access size and load FSM states.
package riscv_defines;

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_READ  = 2'b01,
        MEM_WRITE = 2'b10
    } memaccess_t;

    typedef enum logic [1:0] {
        MASK_BYTE = 2'b00,
        MASK_HALF = 2'b01,
        MASK_WORD = 2'b10
    } mask_mode_t;

    typedef enum logic [2:0] {
        LD_IDLE  = 3'd0,
        LD_REQ0  = 3'd1,
        LD_WAIT0 = 3'd2,
        LD_REQ1  = 3'd3,
        LD_WAIT1 = 3'd4,
        LD_DONE  = 3'd5
    } load_state_t;

    // An access crosses a word boundary when its last byte lands in the next word.
    function automatic logic is_cross(input mask_mode_t mode, input logic [1:0] offset);
        case (mode)
            MASK_HALF: return (offset == 2'd3);
            MASK_WORD: return (offset != 2'd0);
            default:   return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_extract_unit.sv
// Merges the two read words, right-justifies the addressed bytes and extends them.
module load_extract_unit
    import riscv_defines::*;
(
    input  logic [XLEN-1:0] lo_word,
    input  logic [XLEN-1:0] hi_word,
    input  logic [1:0]      byte_offset,
    input  mask_mode_t      mask_mode,
    input  logic            load_unsigned,
    output logic [XLEN-1:0] result
);

    logic [XLEN-1:0] w_shifted;
    logic            w_sign;

    always_comb begin
        w_shifted = XLEN'({hi_word, lo_word} >> {byte_offset, 3'b000});
        w_sign    = 1'b0;
        case (mask_mode)
            MASK_BYTE: begin
                w_sign = w_shifted[7] & ~load_unsigned;
                result = {{24{w_sign}}, w_shifted[7:0]};
            end
            MASK_HALF: begin
                w_sign = w_shifted[15] & ~load_unsigned;
                result = {{16{w_sign}}, w_shifted[15:0]};
            end
            default: result = w_shifted;
        endcase
    end

endmodule

// File: rtl/load_access_unit.sv
// Load request sequencer: issues one or two word-aligned reads and returns the extended result.
module load_access_unit
    import riscv_defines::*;
#(
    parameter bit          ALLOW_MISALIGNED = 1'b1,
    parameter int unsigned ADDR_WIDTH       = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  memaccess_t            memaccess,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  mask_mode_t            mask_mode,
    input  logic                  load_unsigned,
    output logic                  mem_req_valid,
    input  logic                  mem_req_ready,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic                  mem_rsp_valid,
    input  logic [XLEN-1:0]       mem_rdata,
    output logic                  rsp_valid,
    output logic [XLEN-1:0]       rsp_data,
    output logic                  misalign_fault,
    output logic                  busy
);

    load_state_t           r_state;
    logic [1:0]            r_byte_offset;
    mask_mode_t            r_mask_mode;
    logic                  r_load_unsigned;
    logic [ADDR_WIDTH-1:0] r_word_addr;
    logic                  r_cross;
    logic [XLEN-1:0]       r_lo_word;

    logic                  w_req_hs;
    logic                  w_cross;
    logic [XLEN-1:0]       w_lo_word;
    logic [XLEN-1:0]       w_hi_word;
    logic [XLEN-1:0]       w_result;

    assign req_ready = (r_state == LD_IDLE);
    assign busy      = ~req_ready;
    assign w_req_hs  = req_valid && req_ready && (memaccess == MEM_READ);
    assign w_cross   = is_cross(mask_mode, addr[1:0]);

    // Feed the arriving word straight into the extractor so the result registers on the response cycle.
    assign w_lo_word = (r_state == LD_WAIT0) ? mem_rdata : r_lo_word;
    assign w_hi_word = (r_state == LD_WAIT1) ? mem_rdata : '0;

    load_extract_unit u_extract (
        .lo_word       (w_lo_word),
        .hi_word       (w_hi_word),
        .byte_offset   (r_byte_offset),
        .mask_mode     (r_mask_mode),
        .load_unsigned (r_load_unsigned),
        .result        (w_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= LD_IDLE;
            r_byte_offset   <= 2'd0;
            r_mask_mode     <= MASK_BYTE;
            r_load_unsigned <= 1'b0;
            r_word_addr     <= '0;
            r_cross         <= 1'b0;
            r_lo_word       <= '0;
            mem_req_valid   <= 1'b0;
            mem_addr        <= '0;
            rsp_valid       <= 1'b0;
            rsp_data        <= '0;
            misalign_fault  <= 1'b0;
        end else begin
            rsp_valid      <= 1'b0;
            misalign_fault <= 1'b0;
            case (r_state)
                LD_IDLE: begin
                    if (w_req_hs) begin
                        if (w_cross && !ALLOW_MISALIGNED) begin
                            misalign_fault <= 1'b1;
                        end else begin
                            r_byte_offset   <= addr[1:0];
                            r_mask_mode     <= mask_mode;
                            r_load_unsigned <= load_unsigned;
                            r_word_addr     <= {addr[ADDR_WIDTH-1:2], 2'b00};
                            r_cross         <= w_cross;
                            mem_req_valid   <= 1'b1;
                            mem_addr        <= {addr[ADDR_WIDTH-1:2], 2'b00};
                            r_state         <= LD_REQ0;
                        end
                    end
                end
                LD_REQ0: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= LD_WAIT0;
                    end
                end
                LD_WAIT0: begin
                    if (mem_rsp_valid) begin
                        r_lo_word <= mem_rdata;
                        if (r_cross) begin
                            mem_req_valid <= 1'b1;
                            mem_addr      <= r_word_addr + ADDR_WIDTH'(4);
                            r_state       <= LD_REQ1;
                        end else begin
                            rsp_valid <= 1'b1;
                            rsp_data  <= w_result;
                            r_state   <= LD_DONE;
                        end
                    end
                end
                LD_REQ1: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        r_state       <= LD_WAIT1;
                    end
                end
                LD_WAIT1: begin
                    if (mem_rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_data  <= w_result;
                        r_state   <= LD_DONE;
                    end
                end
                LD_DONE: r_state <= LD_IDLE;
                default: r_state <= LD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_access_unit.sv
// Directed bench for load_access_unit: aligned, crossing, stalled, faulting and reset-abandoned loads.
module tb_load_access_unit;
    import riscv_defines::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid2;
    memaccess_t  memaccess;
    logic [31:0] addr;
    mask_mode_t  mask_mode;
    logic        load_unsigned;
    logic        mem_req_ready;
    logic        mdl_rsp_valid = 1'b0;
    logic [31:0] mdl_rdata = '0;
    logic        stray_rsp;
    logic        mem_rsp_valid;

    logic        req_ready, mem_req_valid, rsp_valid, misalign_fault, busy;
    logic [31:0] mem_addr, rsp_data;
    logic        req_ready2, mem_req_valid2, rsp_valid2, misalign_fault2, busy2;
    logic [31:0] mem_addr2, rsp_data2;

    int n_checks = 0;
    int n_err    = 0;
    int rd_count = 0;
    logic [31:0] rd_log [0:63];
    int rsp_cnt  = 0;
    int rsp_cnt2 = 0;
    int fault_cnt = 0;
    int mrv2_cnt = 0;

    assign mem_rsp_valid = mdl_rsp_valid | stray_rsp;

    always #5 clk = ~clk;

    load_access_unit #(.ALLOW_MISALIGNED(1'b1), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .memaccess(memaccess), .addr(addr), .mask_mode(mask_mode), .load_unsigned(load_unsigned),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mdl_rdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .misalign_fault(misalign_fault), .busy(busy)
    );

    load_access_unit #(.ALLOW_MISALIGNED(1'b0), .ADDR_WIDTH(32)) dut_nomis (
        .clk(clk), .rst(rst), .req_valid(req_valid2), .req_ready(req_ready2),
        .memaccess(memaccess), .addr(addr), .mask_mode(mask_mode), .load_unsigned(load_unsigned),
        .mem_req_valid(mem_req_valid2), .mem_req_ready(1'b1), .mem_addr(mem_addr2),
        .mem_rsp_valid(1'b0), .mem_rdata(32'h0),
        .rsp_valid(rsp_valid2), .rsp_data(rsp_data2), .misalign_fault(misalign_fault2), .busy(busy2)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        case (a)
            32'h100: return 32'h8899AABB;
            32'h104: return 32'h11223344;
            default: return 32'hDEADBEEF;
        endcase
    endfunction

    // Zero-wait memory: answers one cycle after each accepted request.
    always @(posedge clk) begin
        mdl_rsp_valid <= 1'b0;
        if (mem_req_valid && mem_req_ready) begin
            mdl_rsp_valid    <= 1'b1;
            mdl_rdata        <= mem_word(mem_addr);
            rd_log[rd_count] <= mem_addr;
            rd_count         <= rd_count + 1;
        end
        if (rsp_valid)       rsp_cnt   <= rsp_cnt + 1;
        if (rsp_valid2)      rsp_cnt2  <= rsp_cnt2 + 1;
        if (misalign_fault)  fault_cnt <= fault_cnt + 1;
        if (mem_req_valid2)  mrv2_cnt  <= mrv2_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_rsp(output logic [31:0] d, output int lat);
        lat = 0;
        d   = '0;
        for (int k = 1; k <= 20; k++) begin
            if (rsp_valid) begin
                lat = k;
                d   = rsp_data;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic do_load(input logic [31:0] a, input mask_mode_t m, input logic u,
                           output logic [31:0] d, output int lat);
        @(negedge clk);
        req_valid = 1'b1; memaccess = MEM_READ; addr = a; mask_mode = m; load_unsigned = u;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; memaccess = MEM_NONE;
        wait_rsp(d, lat);
    endtask

    typedef struct {
        string       name;
        logic [31:0] a;
        mask_mode_t  m;
        logic        u;
        logic [31:0] exp;
        int          lat;
        int          reads;
    } vec_t;

    vec_t vecs [7];

    initial begin
        logic [31:0] d;
        int lat, base, rc;

        vecs[0] = '{"lb_102_s",  32'h102, MASK_BYTE, 1'b0, 32'hFFFFFF99, 3, 1};
        vecs[1] = '{"lb_102_u",  32'h102, MASK_BYTE, 1'b1, 32'h00000099, 3, 1};
        vecs[2] = '{"lh_102_s",  32'h102, MASK_HALF, 1'b0, 32'hFFFF8899, 3, 1};
        vecs[3] = '{"lw_100",    32'h100, MASK_WORD, 1'b0, 32'h8899AABB, 3, 1};
        vecs[4] = '{"lw_101",    32'h101, MASK_WORD, 1'b0, 32'h448899AA, 5, 2};
        vecs[5] = '{"lh_103_s",  32'h103, MASK_HALF, 1'b0, 32'h00004488, 5, 2};
        vecs[6] = '{"bad_mode",  32'h101, mask_mode_t'(2'b11), 1'b0, 32'h008899AA, 3, 1};

        rst = 1'b1; req_valid = 1'b0; req_valid2 = 1'b0; memaccess = MEM_NONE;
        addr = '0; mask_mode = MASK_BYTE; load_unsigned = 1'b0;
        mem_req_ready = 1'b1; stray_rsp = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mem_req_valid", 32'(mem_req_valid), 32'd0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'h0);
        check("rst_fault", 32'(misalign_fault), 32'd0);
        rst = 1'b0;

        // Directed loads against the two-word memory image.
        foreach (vecs[i]) begin
            base = rd_count;
            do_load(vecs[i].a, vecs[i].m, vecs[i].u, d, lat);
            check({vecs[i].name, "_data"}, d, vecs[i].exp);
            check({vecs[i].name, "_lat"}, 32'(lat), 32'(vecs[i].lat));
            check({vecs[i].name, "_reads"}, 32'(rd_count - base), 32'(vecs[i].reads));
            check({vecs[i].name, "_addr0"}, rd_log[base], 32'h100);
            if (vecs[i].reads == 2) check({vecs[i].name, "_addr1"}, rd_log[base + 1], 32'h104);
        end

        // Non-read access is ignored.
        base = rd_count;
        @(negedge clk);
        req_valid = 1'b1; memaccess = MEM_WRITE; addr = 32'h100; mask_mode = MASK_WORD;
        @(negedge clk);
        req_valid = 1'b0; memaccess = MEM_NONE;
        check("write_ignored_ready", 32'(req_ready), 32'd1);
        check("write_ignored_mrv", 32'(mem_req_valid), 32'd0);
        repeat (2) @(negedge clk);
        check("write_ignored_reads", 32'(rd_count - base), 32'd0);

        // Memory stalls the request for three cycles; a second request must not slip in.
        base = rd_count; rc = rsp_cnt;
        mem_req_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; memaccess = MEM_READ; addr = 32'h100; mask_mode = MASK_WORD; load_unsigned = 1'b0;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            addr = 32'h104;
            check("stall_mrv", 32'(mem_req_valid), 32'd1);
            check("stall_addr", mem_addr, 32'h100);
            check("stall_ready", 32'(req_ready), 32'd0);
        end
        req_valid = 1'b0; memaccess = MEM_NONE; mem_req_ready = 1'b1;
        @(negedge clk);
        wait_rsp(d, lat);
        check("stall_data", d, 32'h8899AABB);
        repeat (4) @(negedge clk);
        check("stall_reads", 32'(rd_count - base), 32'd1);
        check("stall_one_rsp", 32'(rsp_cnt - rc), 32'd1);
        check("no_fault_allowed", 32'(fault_cnt), 32'd0);

        // Misaligned word with splitting disabled faults without touching memory.
        @(negedge clk);
        req_valid2 = 1'b1; memaccess = MEM_READ; addr = 32'h102; mask_mode = MASK_WORD;
        @(posedge clk);
        @(negedge clk);
        req_valid2 = 1'b0; memaccess = MEM_NONE;
        check("mis_fault_pulse", 32'(misalign_fault2), 32'd1);
        check("mis_ready", 32'(req_ready2), 32'd1);
        @(negedge clk);
        check("mis_fault_clear", 32'(misalign_fault2), 32'd0);
        repeat (3) @(negedge clk);
        check("mis_no_mem_req", 32'(mrv2_cnt), 32'd0);
        check("mis_no_rsp", 32'(rsp_cnt2), 32'd0);

        // Reset while waiting for the second word abandons the load.
        base = rd_count;
        @(negedge clk);
        req_valid = 1'b1; memaccess = MEM_READ; addr = 32'h101; mask_mode = MASK_WORD;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0; memaccess = MEM_NONE;
        repeat (3) @(negedge clk);
        check("rstw1_reads", 32'(rd_count - base), 32'd2);
        rst = 1'b1;
        #1;
        check("rstw1_mrv", 32'(mem_req_valid), 32'd0);
        check("rstw1_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rstw1_rsp_data", rsp_data, 32'h0);
        check("rstw1_mem_addr", mem_addr, 32'h0);
        check("rstw1_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rc = rsp_cnt;
        @(negedge clk);
        check("rstw1_ready_after", 32'(req_ready), 32'd1);
        stray_rsp = 1'b1;
        @(negedge clk);
        stray_rsp = 1'b0;
        repeat (3) @(negedge clk);
        check("stray_no_rsp", 32'(rsp_cnt - rc), 32'd0);
        check("stray_idle", 32'(req_ready), 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
